// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// state enum, mux selects, ALU ops, opcodes/functs, exception causes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_FETCH_IR,
    ST_DECODE,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_BRANCH,
    ST_JUMP,
    ST_EXC_ILL,
    ST_EXC_OVF
  } state_e;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_A    = 2'b01;
  localparam logic [1:0] SRCA_J26  = 2'b10;
  localparam logic [1:0] SRCA_MDR  = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ILL  = 2'b01;
  localparam logic [1:0] EXC_OVF  = 2'b10;

  typedef struct packed {
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       epc_write;
    logic [1:0] exc_cause;
    logic       done;
  } ctrl_t;

  function automatic logic [2:0] funct_aluop(
    input logic [5:0] fn
  );
    logic [2:0] op;
    unique case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    logic ok;
    unique case (op)
      OP_R: ok = (fn == FN_ADD) || (fn == FN_SUB)
              || (fn == FN_AND) || (fn == FN_OR)
              || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI,
      OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait down-counter shared by FETCH, MEM_RD and MEM_WR.
// load_i rearms it; done_o is high on the last cycle of the access.
module ctrl_wait_cnt #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic done_o
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(MEM_WAIT - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM (fetch/decode/execute/mem/writeback).
// Define MC_CTRL_EXC_EN to trap illegal instructions and overflow.
module mc_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] w_Opcode,
  input  logic [5:0] w_Funct,
  input  logic       w_Zero,
  input  logic       w_Overflow,
  output logic [1:0] w_ALUSrcA,
  output logic [1:0] w_ALUSrcB,
  output logic [2:0] w_ALUOp,
  output logic [1:0] w_PCSource,
  output logic       w_PCWrite,
  output logic       w_PCWriteCond,
  output logic       w_IorD,
  output logic       w_MemRead,
  output logic       w_MemWrite,
  output logic       w_IRWrite,
  output logic       w_RegWrite,
  output logic       w_RegDst,
  output logic       w_MemToReg,
  output logic       w_EPCWrite,
  output logic [1:0] w_ExcCause,
  output logic       w_InstrDone
);

`ifdef MC_CTRL_EXC_EN
  localparam logic   EXC_EN = 1'b1;
  localparam state_e ST_ILL = ST_EXC_ILL;
`else
  localparam logic   EXC_EN = 1'b0;
  localparam state_e ST_ILL = ST_FETCH;
`endif

  state_e state_q, state_d;
  ctrl_t  c;
  logic   wait_done;
  logic   legal;
  logic   addsub;
  logic   zero_unused;

  // Zero only qualifies PCWriteCond inside the datapath.
  assign zero_unused = w_Zero;
  assign legal  = is_legal(w_Opcode, w_Funct);
  assign addsub = (w_Funct == FN_ADD)
               || (w_Funct == FN_SUB);

  ctrl_wait_cnt #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .load_i (state_d != state_q),
    .done_o (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:    state_d = ST_FETCH;
      ST_FETCH:
        if (wait_done) state_d = ST_FETCH_IR;
      ST_FETCH_IR: state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (w_Opcode)
          OP_R:    state_d = legal ? ST_EXEC_R
                                   : ST_ILL;
          OP_ADDI: state_d = ST_EXEC_I;
          OP_LW,
          OP_SW:   state_d = ST_MEM_ADDR;
          OP_BEQ:  state_d = ST_BRANCH;
          OP_J:    state_d = ST_JUMP;
          default: state_d = ST_ILL;
        endcase
      end
      ST_EXEC_R:
        state_d = (EXC_EN && w_Overflow && addsub)
                ? ST_EXC_OVF : ST_R_WB;
      ST_EXEC_I:
        state_d = (EXC_EN && w_Overflow)
                ? ST_EXC_OVF : ST_I_WB;
      ST_MEM_ADDR:
        state_d = (w_Opcode == OP_SW)
                ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:
        if (wait_done) state_d = ST_MEM_WB;
      ST_MEM_WR:
        if (wait_done) state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state_q)
      ST_RESET: ;
      ST_FETCH: c.mem_read = 1'b1;
      ST_FETCH_IR: begin
        c.ir_write = 1'b1;
        c.srcb     = SRCB_4;
        c.pc_write = 1'b1;
      end
      ST_DECODE: begin
        c.srcb = SRCB_IMM4;
        c.done = !EXC_EN && !legal;
      end
      ST_EXEC_R: begin
        c.srca   = SRCA_A;
        c.srcb   = SRCB_B;
        c.alu_op = funct_aluop(w_Funct);
      end
      ST_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        c.srca = SRCA_A;
        c.srcb = SRCB_IMM;
      end
      ST_I_WB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      ST_MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.done       = 1'b1;
      end
      ST_MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.done      = wait_done;
      end
      ST_BRANCH: begin
        c.srca          = SRCA_A;
        c.alu_op        = ALU_SUB;
        c.pc_src        = PCS_ALUOUT;
        c.pc_write_cond = 1'b1;
        c.done          = 1'b1;
      end
      ST_JUMP: begin
        c.pc_src   = PCS_JUMP;
        c.pc_write = 1'b1;
        c.done     = 1'b1;
      end
      ST_EXC_ILL, ST_EXC_OVF: begin
        c.epc_write = 1'b1;
        c.pc_src    = PCS_EXC;
        c.pc_write  = 1'b1;
        c.done      = 1'b1;
        c.exc_cause = (state_q == ST_EXC_ILL)
                    ? EXC_ILL : EXC_OVF;
      end
      default: ;
    endcase
    if (!EXC_EN) begin
      c.epc_write = 1'b0;
      c.exc_cause = EXC_NONE;
    end
    // Nothing may write while reset is held.
    if (reset) c = '0;
  end

  assign w_ALUSrcA     = c.srca;
  assign w_ALUSrcB     = c.srcb;
  assign w_ALUOp       = c.alu_op;
  assign w_PCSource    = c.pc_src;
  assign w_PCWrite     = c.pc_write;
  assign w_PCWriteCond = c.pc_write_cond;
  assign w_IorD        = c.iord;
  assign w_MemRead     = c.mem_read;
  assign w_MemWrite    = c.mem_write;
  assign w_IRWrite     = c.ir_write;
  assign w_RegWrite    = c.reg_write;
  assign w_RegDst      = c.reg_dst;
  assign w_MemToReg    = c.mem_to_reg;
  assign w_EPCWrite    = c.epc_write;
  assign w_ExcCause    = c.exc_cause;
  assign w_InstrDone   = c.done;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: MEM_WAIT=1 and MEM_WAIT=3
// instances share stimulus; hand-computed per-cycle expectations.
module tb_mc_control_unit;

  typedef struct packed {
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcs;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       epcw;
    logic [1:0] exc;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] w_Opcode = '0;
  logic [5:0] w_Funct = '0;
  logic       w_Zero = 1'b0;
  logic       w_Overflow = 1'b0;
  logic       sel3 = 1'b0;

  logic [1:0] a1, b1, ps1, a3, b3, ps3, ec1, ec3;
  logic [2:0] op1, op3;
  logic pw1, pc1, io1, mr1, mw1, ir1, rw1;
  logic rd1, mt1, ep1, dn1;
  logic pw3, pc3, io3, mr3, mw3, ir3, rw3;
  logic rd3, mt3, ep3, dn3;
  obs_t o1, o3, o;
  obs_t hist [0:40];
  obs_t nxt;

  int errors = 0;
  int checks = 0;
  int len;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_WAIT(1)) u1 (
    .clk(clk), .reset(reset),
    .w_Opcode(w_Opcode), .w_Funct(w_Funct),
    .w_Zero(w_Zero), .w_Overflow(w_Overflow),
    .w_ALUSrcA(a1), .w_ALUSrcB(b1),
    .w_ALUOp(op1), .w_PCSource(ps1),
    .w_PCWrite(pw1), .w_PCWriteCond(pc1),
    .w_IorD(io1), .w_MemRead(mr1),
    .w_MemWrite(mw1), .w_IRWrite(ir1),
    .w_RegWrite(rw1), .w_RegDst(rd1),
    .w_MemToReg(mt1), .w_EPCWrite(ep1),
    .w_ExcCause(ec1), .w_InstrDone(dn1)
  );

  mc_control_unit #(.MEM_WAIT(3)) u3 (
    .clk(clk), .reset(reset),
    .w_Opcode(w_Opcode), .w_Funct(w_Funct),
    .w_Zero(w_Zero), .w_Overflow(w_Overflow),
    .w_ALUSrcA(a3), .w_ALUSrcB(b3),
    .w_ALUOp(op3), .w_PCSource(ps3),
    .w_PCWrite(pw3), .w_PCWriteCond(pc3),
    .w_IorD(io3), .w_MemRead(mr3),
    .w_MemWrite(mw3), .w_IRWrite(ir3),
    .w_RegWrite(rw3), .w_RegDst(rd3),
    .w_MemToReg(mt3), .w_EPCWrite(ep3),
    .w_ExcCause(ec3), .w_InstrDone(dn3)
  );

  assign o1 = {a1, b1, op1, ps1, pw1, pc1, io1,
               mr1, mw1, ir1, rw1, rd1, mt1, ep1,
               ec1, dn1};
  assign o3 = {a3, b3, op3, ps3, pw3, pc3, io3,
               mr3, mw3, ir3, rw3, rd3, mt3, ep3,
               ec3, dn3};
  assign o = sel3 ? o3 : o1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then record one instruction cycle by cycle
  // (cycle 1 = first FETCH cycle) until InstrDone.
  task automatic run(input logic s3,
                     input logic [5:0] op,
                     input logic [5:0] fn,
                     input logic z,
                     input logic ov);
    sel3 = s3;
    w_Opcode = op;
    w_Funct = fn;
    w_Zero = z;
    w_Overflow = ov;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i <= 40; i++) hist[i] = '0;
    len = 0;
    for (int c = 1; c < 40; c++) begin
      hist[c] = o;
      if (o.done) begin
        len = c;
        break;
      end
      step();
    end
    chk("done_seen", (len != 0), 1);
    step();
    nxt = o;
  endtask

  function automatic int count_rw(input int n);
    int k = 0;
    for (int i = 1; i <= n; i++)
      if (hist[i].rw) k++;
    return k;
  endfunction

  logic [5:0] fns [5];
  logic [2:0] ops [5];
  int rwseen;
  int k;
  int kf;

  initial begin
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    // reset asserted mid-lw on the MEM_WAIT=3 unit
    sel3 = 1'b1;
    w_Opcode = 6'h23;
    step();
    step();
    chk("rst_init", o, 0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 6; i++) step();
    chk("midlw_memrd", {o.mrd, o.iord}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_immediate", o, 0);
    rwseen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o.rw) rwseen++;
      chk("rst_hold", o, 0);
    end
    reset = 1'b0;
    #1;
    chk("rst_state_out", o, 0);
    step();
    chk("rst_fetch", {o.mrd, o.iord}, 2'b10);
    chk("rst_no_rw", rwseen, 0);

    // R-type ALU ops, MEM_WAIT=1
    for (int i = 0; i < 5; i++) begin
      run(1'b0, 6'h00, fns[i], 1'b0, 1'b0);
      chk("r_len", len, 5);
      chk("r_exec_src",
          {hist[4].srca, hist[4].srcb}, 4'b0100);
      chk("r_aluop", hist[4].aluop, ops[i]);
      chk("r_wb", {hist[5].rw, hist[5].rdst,
                   hist[5].m2r}, 3'b110);
      chk("r_next_fetch",
          {nxt.done, nxt.mrd}, 2'b01);
    end
    chk("fetch_out", {hist[1].mrd, hist[1].iord},
        2'b10);
    chk("fetch_ir", {hist[2].irw, hist[2].pcw,
                     hist[2].srcb}, 4'b1101);
    chk("decode_srcb", hist[3].srcb, 2'b11);

    // lw with MEM_WAIT=3
    run(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    chk("lw_len", len, 10);
    k = 0;
    kf = 0;
    for (int i = 1; i <= 10; i++) begin
      if (hist[i].mrd && hist[i].iord) k++;
      if (hist[i].mrd && !hist[i].iord) kf++;
    end
    chk("lw_memrd_cycles", k, 3);
    chk("lw_fetch_cycles", kf, 3);
    chk("lw_wb", {hist[10].m2r, hist[10].rw,
                  hist[10].rdst}, 3'b110);
    chk("lw_rw_once", count_rw(10), 1);

    // sw, both wait settings
    run(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0);
    chk("sw_len", len, 5);
    chk("sw_wr", {hist[5].mwr, hist[5].iord}, 2'b11);
    chk("sw_addr", {hist[4].srca, hist[4].srcb},
        4'b0110);
    run(1'b1, 6'h2B, 6'h00, 1'b0, 1'b0);
    chk("sw3_len", len, 9);
    k = 0;
    for (int i = 1; i <= 9; i++)
      if (hist[i].mwr) k++;
    chk("sw3_wr_cycles", k, 3);

    // beq with Zero low then high
    for (int z = 0; z < 2; z++) begin
      run(1'b0, 6'h04, 6'h00, z[0], 1'b0);
      chk("beq_len", len, 4);
      chk("beq_ctl", {hist[4].pcwc, hist[4].pcs,
                      hist[4].pcw}, 4'b1010);
      chk("beq_alu", {hist[4].srca, hist[4].aluop},
          5'b01001);
      chk("beq_pcw_c3", hist[3].pcw, 0);
    end

    // j
    run(1'b0, 6'h02, 6'h00, 1'b0, 1'b0);
    chk("j_len", len, 4);
    chk("j_ctl", {hist[4].pcw, hist[4].pcs}, 3'b110);

    // illegal opcode and illegal R funct
    for (int t = 0; t < 2; t++) begin
      if (t == 0)
        run(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0);
      else
        run(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
`ifdef MC_CTRL_EXC_EN
      chk("ill_len", len, 4);
      chk("ill_exc", {hist[4].exc, hist[4].epcw,
                      hist[4].pcs, hist[4].pcw},
          6'b011111);
`else
      chk("ill_len", len, 3);
      chk("ill_nowr", {hist[3].pcw, hist[3].pcwc,
                       hist[3].mwr, hist[3].rw,
                       hist[3].irw, hist[3].epcw,
                       hist[3].exc}, 8'h00);
`endif
      chk("ill_refetch", nxt.mrd, 1);
    end

    // addi, then addi and add with overflow
    run(1'b0, 6'h08, 6'h00, 1'b0, 1'b0);
    chk("addi_len", len, 5);
    chk("addi_exec", {hist[4].srca, hist[4].srcb},
        4'b0110);
    chk("addi_wb", {hist[5].rw, hist[5].rdst},
        2'b10);
    run(1'b0, 6'h08, 6'h00, 1'b0, 1'b1);
    chk("addi_ov_len", len, 5);
`ifdef MC_CTRL_EXC_EN
    chk("addi_ov_exc", {hist[5].exc, hist[5].epcw,
                        hist[5].pcs}, 5'b10111);
    chk("addi_ov_norw", count_rw(5), 0);
`else
    chk("addi_ov_wb", hist[5].rw, 1);
    chk("addi_ov_noexc", {hist[5].exc,
                          hist[5].epcw}, 3'b000);
`endif
    run(1'b0, 6'h00, 6'h20, 1'b0, 1'b1);
`ifdef MC_CTRL_EXC_EN
    chk("add_ov_exc", hist[5].exc, 2'b10);
    chk("add_ov_norw", count_rw(5), 0);
`else
    chk("add_ov_wb", {hist[5].rw, hist[5].rdst},
        2'b11);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
